// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : spi_controller
// Description : SPI mode-0 initiator; shifts one 16-bit {rw, addr, data}
//               frame per command and returns the last 8 CIPO bits.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       busy,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    input  logic       CIPO
);

    localparam int c_CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    // The peripheral's 2-FF sync plus edge detect needs at least 4 clk per half-period
    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("spi_controller: CLK_DIV must be >= 4");
    end
    if (GAP_CYC < 4) begin : g_bad_gap_cyc
        $error("spi_controller: GAP_CYC must be >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_TRAIL = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_phase;
    logic [3:0]         r_bit_cnt;
    logic [14:0]        r_tx;      // bit 15 (rw) goes straight to COPI at accept
    logic [7:0]         r_rx;      // only the last 8 samples are ever returned
    logic               r_cipo_meta;
    logic               r_cipo_sync;

    wire w_div_end = (r_phase == c_DIV_LAST);
    wire w_gap_end = (r_phase == c_GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cipo_meta <= 1'b0;
            r_cipo_sync <= 1'b0;
        end else begin
            r_cipo_meta <= CIPO;
            r_cipo_sync <= r_cipo_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bit_cnt <= 4'd0;
            r_tx      <= 15'd0;
            r_rx      <= 8'd0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 8'd0;
            nCS       <= 1'b1;
            SCLK      <= 1'b0;
            COPI      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_tx      <= {cmd_addr, cmd_wdata};
                        COPI      <= cmd_rw;
                        nCS       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        r_phase   <= '0;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (w_div_end) begin
                        SCLK    <= 1'b1;
                        r_phase <= '0;
                        r_state <= S_HIGH;
                    end else begin
                        r_phase <= r_phase + c_ONE;
                    end
                end
                S_HIGH: begin
                    if (w_div_end) begin
                        r_rx    <= {r_rx[6:0], r_cipo_sync};
                        SCLK    <= 1'b0;
                        r_phase <= '0;
                        if (r_bit_cnt == 4'd15) begin
                            r_state <= S_TRAIL;
                        end else begin
                            COPI      <= r_tx[14];
                            r_tx      <= {r_tx[13:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_state   <= S_LOW;
                        end
                    end else begin
                        r_phase <= r_phase + c_ONE;
                    end
                end
                S_LOW: begin
                    if (w_div_end) begin
                        SCLK    <= 1'b1;
                        r_phase <= '0;
                        r_state <= S_HIGH;
                    end else begin
                        r_phase <= r_phase + c_ONE;
                    end
                end
                S_TRAIL: begin
                    if (w_div_end) begin
                        nCS     <= 1'b1;
                        COPI    <= 1'b0;
                        r_phase <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_phase <= r_phase + c_ONE;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        rd_data   <= r_rx;
                        r_phase   <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_phase <= r_phase + c_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_controller
// Description : Directed self-checking bench for spi_controller with a small
//               SPI target model (register bank + CIPO driver).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid4, cmd_valid7, cmd_rw, cipo, sel;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       ready4, done4, busy4, ncs4, sclk4, copi4;
    logic       ready7, done7, busy7, ncs7, sclk7, copi7;
    logic [7:0] rd4, rd7;

    spi_controller #(.CLK_DIV(4), .GAP_CYC(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_ready(ready4),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_data(rd4), .done(done4), .busy(busy4),
        .nCS(ncs4), .SCLK(sclk4), .COPI(copi4), .CIPO(cipo)
    );

    spi_controller #(.CLK_DIV(7), .GAP_CYC(8)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid7), .cmd_ready(ready7),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_data(rd7), .done(done7), .busy(busy7),
        .nCS(ncs7), .SCLK(sclk7), .COPI(copi7), .CIPO(cipo)
    );

    wire       w_ncs   = sel ? ncs7   : ncs4;
    wire       w_sclk  = sel ? sclk7  : sclk4;
    wire       w_copi  = sel ? copi7  : copi4;
    wire       w_done  = sel ? done7  : done4;
    wire       w_ready = sel ? ready7 : ready4;
    wire       w_busy  = sel ? busy7  : busy4;
    wire [7:0] w_rd    = sel ? rd7    : rd4;

    // Target model: decodes complete 16-bit frames, drives cipo_byte in the data phase
    logic [7:0]  regs [0:127] = '{default: 8'h00};
    logic [7:0]  cipo_byte;
    logic [15:0] shift_in = 16'h0;
    logic [15:0] last_frame = 16'h0;
    int          rise_cnt = 0;
    int          last_rises = 0;
    logic        prev_ncs = 1'b1;
    logic        prev_sclk = 1'b0;

    always @(w_ncs or w_sclk) begin
        if (prev_ncs === 1'b1 && w_ncs === 1'b0) begin
            rise_cnt = 0;
            shift_in = 16'h0;
            cipo     = 1'b0;
        end else if (prev_ncs === 1'b0 && w_ncs === 1'b1) begin
            last_frame = shift_in;
            last_rises = rise_cnt;
            if (rise_cnt == 16 && shift_in[15])
                regs[shift_in[14:8]] = shift_in[7:0];
            cipo = 1'b0;
        end
        if (w_ncs === 1'b0 && prev_sclk === 1'b0 && w_sclk === 1'b1) begin
            rise_cnt = rise_cnt + 1;
            shift_in = {shift_in[14:0], w_copi};
        end
        if (w_ncs === 1'b0 && prev_sclk === 1'b1 && w_sclk === 1'b0 &&
            rise_cnt >= 8 && rise_cnt < 16)
            cipo = cipo_byte[15 - rise_cnt];
        prev_ncs  = w_ncs;
        prev_sclk = w_sclk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) cmd_valid7 = v;
        else     cmd_valid4 = v;
    endtask

    task automatic note_run(input logic lvl, input int len,
                            inout int hmin, inout int hmax, inout int lmin, inout int lmax);
        if (lvl) begin
            if (len < hmin) hmin = len;
            if (len > hmax) hmax = len;
        end else begin
            if (len < lmin) lmin = len;
            if (len > lmax) lmax = len;
        end
    endtask

    // One frame; cycle 0 is the handshake cycle, optional ignored cmd_valid pulse mid-frame
    task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                             input bit poke, output int lat, output int nlow, output int ndone,
                             output int hmin, output int hmax, output int lmin, output int lmax);
        int   run;
        bit   in_fr;
        logic prev_s;
        lat = -1; nlow = 0; ndone = 0;
        hmin = 1000; hmax = 0; lmin = 1000; lmax = 0;
        run = 0; in_fr = 0; prev_s = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2000 && !w_ready; k++) @(negedge clk);
        cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd;
        set_valid(1'b1);
        for (int i = 1; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1) set_valid(1'b0);
            if (poke && i == 60) begin
                cmd_rw = ~rw; cmd_addr = addr ^ 7'h7F; cmd_wdata = ~wd;
                set_valid(1'b1);
            end
            if (poke && i == 61) set_valid(1'b0);
            if (w_done) begin
                ndone++;
                if (lat < 0) lat = i;
            end
            if (!w_ncs) begin
                nlow++;
                if (in_fr && w_sclk == prev_s) run++;
                else begin
                    if (in_fr) note_run(prev_s, run, hmin, hmax, lmin, lmax);
                    run = 1; in_fr = 1;
                end
                prev_s = w_sclk;
            end else if (in_fr) begin
                note_run(prev_s, run, hmin, hmax, lmin, lmax);
                in_fr = 0;
            end
            if (lat >= 0 && i >= lat + 20) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat, nlow, ndone, hmin, hmax, lmin, lmax;
        bit   found, saw_done;
        int   idx, dones, cyc, last_done, sp_min, sp_max, gap_run, gap_min, gap_max;
        bit   seen_low;
        logic [7:0] bb_data [0:4];

        cmd_valid4 = 0; cmd_valid7 = 0; cmd_rw = 0; cmd_addr = 0; cmd_wdata = 0;
        sel = 0; cipo_byte = 8'h00;

        rst_n = 0;
        repeat (3) @(negedge clk);
        check("reset_ncs",   w_ncs,   1'b1);
        check("reset_sclk",  w_sclk,  1'b0);
        check("reset_copi",  w_copi,  1'b0);
        check("reset_ready", w_ready, 1'b1);
        check("reset_busy",  w_busy,  1'b0);
        check("reset_done",  w_done,  1'b0);
        check("reset_rd",    w_rd,    8'h00);
        rst_n = 1;
        @(negedge clk);

        // Write 0x80 to 0x04; CIPO carries 0x3C which a write also returns
        cipo_byte = 8'h3C;
        run_frame(1'b1, 7'h04, 8'h80, 0, lat, nlow, ndone, hmin, hmax, lmin, lmax);
        check("wr_frame",   last_frame, 16'h8480);
        check("wr_rises",   last_rises, 16);
        check("wr_ncs_low", nlow, 132);
        check("wr_latency", lat, 141);
        check("wr_ndone",   ndone, 1);
        check("wr_reg04",   regs[4], 8'h80);
        check("wr_hi_min",  hmin, 4);
        check("wr_hi_max",  hmax, 4);
        check("wr_lo_min",  lmin, 4);
        check("wr_lo_max",  lmax, 4);
        check("wr_rd_data", w_rd, 8'h3C);
        check("wr_busy",    w_busy, 1'b0);

        // Read 0x01 with the target returning 0xA5
        cipo_byte = 8'hA5;
        run_frame(1'b0, 7'h01, 8'h00, 0, lat, nlow, ndone, hmin, hmax, lmin, lmax);
        check("rd_frame",   last_frame, 16'h0100);
        check("rd_data",    w_rd, 8'hA5);
        check("rd_reg01",   regs[1], 8'h00);
        check("rd_reg04",   regs[4], 8'h80);
        check("rd_latency", lat, 141);

        // Reset during HIGH of bit 7 (9th SCLK high) of a write 0xFF to 0x00
        cipo_byte = 8'h00;
        @(negedge clk);
        cmd_rw = 1; cmd_addr = 7'h00; cmd_wdata = 8'hFF;
        set_valid(1'b1);
        @(negedge clk);
        set_valid(1'b0);
        found = 0;
        for (int k = 0; k < 500; k++) begin
            if (rise_cnt == 9 && w_sclk && !w_ncs) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reached_bit7", found, 1'b1);
        #2 rst_n = 0;
        #1;
        check("rst_async_ncs",  w_ncs,  1'b1);
        check("rst_async_sclk", w_sclk, 1'b0);
        check("rst_async_done", w_done, 1'b0);
        @(negedge clk);
        check("rst_rd_cleared", w_rd, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1;
        saw_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (w_done) saw_done = 1;
        end
        check("rst_no_done", saw_done, 1'b0);
        check("rst_ready",   w_ready, 1'b1);
        check("rst_reg00",   regs[0], 8'h00);

        // Five back-to-back writes with cmd_valid held high
        bb_data[0] = 8'h11; bb_data[1] = 8'h22; bb_data[2] = 8'h33;
        bb_data[3] = 8'h44; bb_data[4] = 8'h55;
        @(negedge clk);
        idx = 0; dones = 0; cyc = 0; last_done = -1;
        sp_min = 100000; sp_max = 0; gap_run = 0; gap_min = 100000; gap_max = 0; seen_low = 0;
        cmd_rw = 1; cmd_addr = 7'h00; cmd_wdata = bb_data[0];
        set_valid(1'b1);
        while (dones < 5 && cyc < 1500) begin
            @(negedge clk);
            cyc++;
            if (w_ncs) gap_run++;
            else begin
                if (seen_low && gap_run > 0) begin
                    if (gap_run < gap_min) gap_min = gap_run;
                    if (gap_run > gap_max) gap_max = gap_run;
                end
                gap_run = 0;
                seen_low = 1;
            end
            if (w_done) begin
                dones++;
                if (last_done >= 0) begin
                    if (cyc - last_done < sp_min) sp_min = cyc - last_done;
                    if (cyc - last_done > sp_max) sp_max = cyc - last_done;
                end
                last_done = cyc;
                idx++;
                if (idx < 5) begin
                    cmd_addr = 7'(idx); cmd_wdata = bb_data[idx];
                end else begin
                    set_valid(1'b0);
                end
            end
        end
        set_valid(1'b0);
        check("b2b_dones",      dones, 5);
        check("b2b_first_lat",  last_done - 4 * sp_max, 141);
        check("b2b_spacing_lo", sp_min, 141);
        check("b2b_spacing_hi", sp_max, 141);
        check("b2b_gap_lo",     gap_min, 9);
        check("b2b_gap_hi",     gap_max, 9);
        for (int r = 0; r < 5; r++)
            check($sformatf("b2b_reg%0d", r), regs[r], bb_data[r]);

        // Mid-frame cmd_valid pulse with different fields is ignored
        run_frame(1'b1, 7'h06, 8'h5A, 1, lat, nlow, ndone, hmin, hmax, lmin, lmax);
        check("poke_frame",   last_frame, 16'h865A);
        check("poke_ndone",   ndone, 1);
        check("poke_latency", lat, 141);
        check("poke_reg06",   regs[6], 8'h5A);
        check("poke_reg79",   regs[7'h79], 8'h00);

        // CLK_DIV = 7 instance
        sel = 1;
        run_frame(1'b1, 7'h05, 8'hC3, 0, lat, nlow, ndone, hmin, hmax, lmin, lmax);
        check("div7_hi_min",  hmin, 7);
        check("div7_hi_max",  hmax, 7);
        check("div7_lo_min",  lmin, 7);
        check("div7_lo_max",  lmax, 7);
        check("div7_ncs_low", nlow, 231);
        check("div7_latency", lat, 240);
        check("div7_reg05",   regs[5], 8'hC3);
        check("div7_rises",   last_rises, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
